// File: rtl/motor_emu_if.sv
// Signal bundle between a motor controller (master) and the motor/encoder emulator (slave).
interface motor_emu_if #(
  parameter int SW = 11
);
  logic                motor_pwm;
  logic                motor_en;
  logic                motor_dir;
  logic                motor_encdr;
  logic [SW-1:0]       speed;
  logic signed [31:0]  position;
  logic [1:0]          mstate;
  logic                win_done;

  modport master (
    output motor_pwm, motor_en, motor_dir,
    input  motor_encdr, speed, position, mstate, win_done
  );

  modport slave (
    input  motor_pwm, motor_en, motor_dir,
    output motor_encdr, speed, position, mstate, win_done
  );
endinterface

// File: rtl/motor_emu.sv
// Motor emulator: measures PWM duty per window, slews speed toward it, and
// integrates speed into an encoder square wave plus a signed position count.
module motor_emu #(
  parameter int PERIOD = 1024,
  parameter int ACCEL  = 16,
  parameter int ACC_W  = 20
) (
  input  logic        WF_CLK,
  input  logic        rst,
  motor_emu_if.slave  bus
);
  localparam int SW  = $clog2(PERIOD + 1);
  localparam int SW1 = SW + 1;
  localparam int WW  = $clog2(PERIOD);
  localparam int AW1 = ACC_W + 1;
  localparam logic [WW-1:0] WLAST = WW'(PERIOD - 1);
  localparam logic [SW:0]   STEP  = SW1'(ACCEL);

  typedef enum logic [1:0] {
    S_STOP   = 2'd0,
    S_ACCEL  = 2'd1,
    S_CRUISE = 2'd2,
    S_DECEL  = 2'd3
  } mstate_t;

  logic [WW-1:0]       wcnt;
  logic [SW-1:0]       dacc;
  logic [SW-1:0]       speed_q;
  mstate_t             state_q;
  logic [ACC_W-1:0]    phase;
  logic                enc_q;
  logic signed [31:0]  pos_q;
  logic                wd_q;

  logic                drive;
  logic                win_close;
  logic [SW-1:0]       target;
  logic [SW-1:0]       speed_nx;
  mstate_t             state_nx;
  logic [ACC_W:0]      phase_sum;

  // Step toward the target by at most STEP; the gap is taken before the step so nothing wraps.
  function automatic logic [SW-1:0] slew(input logic [SW-1:0] cur, input logic [SW-1:0] tgt);
    logic [SW:0] c;
    logic [SW:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c)
      return ((t - c) > STEP) ? SW'(c + STEP) : tgt;
    else if (t < c)
      return ((c - t) > STEP) ? SW'(c - STEP) : tgt;
    else
      return cur;
  endfunction

  function automatic mstate_t classify(input logic [SW-1:0] s, input logic [SW-1:0] tgt);
    if (s == '0 && tgt == '0) return S_STOP;
    else if (s < tgt)         return S_ACCEL;
    else if (s > tgt)         return S_DECEL;
    else                      return S_CRUISE;
  endfunction

  always_comb begin
    drive     = bus.motor_pwm & bus.motor_en;
    win_close = (wcnt == WLAST);
    target    = dacc + SW'(drive);
    speed_nx  = speed_q;
    state_nx  = state_q;
    if (win_close) begin
      speed_nx = slew(speed_q, target);
      state_nx = classify(speed_nx, target);
    end
    // Carry out of the phase sum is the encoder tick; zero speed leaves everything parked.
    phase_sum = {1'b0, phase} + AW1'(speed_q);
  end

  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      wcnt    <= '0;
      dacc    <= '0;
      speed_q <= '0;
      state_q <= S_STOP;
      phase   <= '0;
      enc_q   <= 1'b0;
      pos_q   <= '0;
      wd_q    <= 1'b0;
    end else begin
      wcnt    <= win_close ? '0 : wcnt + 1'b1;
      dacc    <= win_close ? '0 : target;
      speed_q <= speed_nx;
      state_q <= state_nx;
      wd_q    <= win_close;
      phase   <= phase_sum[ACC_W-1:0];
      if (phase_sum[ACC_W]) begin
        enc_q <= ~enc_q;
        pos_q <= bus.motor_dir ? pos_q - 32'sd1 : pos_q + 32'sd1;
      end
    end
  end

  assign bus.motor_encdr = enc_q;
  assign bus.speed       = speed_q;
  assign bus.position    = pos_q;
  assign bus.mstate      = state_q;
  assign bus.win_done    = wd_q;
endmodule

// File: doc/motor_emu.md
MOTOR_EMU -- requirements
Module: motor_emu

Interface
REQ-001 Parameter PERIOD, default 1024: duty-measurement window length in clocks; legal range 2..65535.
REQ-002 Parameter ACCEL, default 16: maximum speed change per window, in speed units; legal range 1..PERIOD.
REQ-003 Parameter ACC_W, default 20: phase-accumulator width in bits; SW = $clog2(PERIOD+1) and ACC_W > SW.
REQ-004 WF_CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 motor_pwm  in  1  PWM drive from the motor controller; sampled every clock.
REQ-007 motor_en  in  1  driver enable; PWM counts as drive only while high.
REQ-008 motor_dir  in  1  direction; 0 = forward, 1 = reverse.
REQ-009 motor_encdr  out  1  emulated encoder square wave; toggles once per phase overflow.
REQ-010 speed  out  SW  current emulated speed, in duty clocks per window.
REQ-011 position  out  32  signed encoder-edge count.
REQ-012 mstate  out  2  motion state: 0 STOPPED, 1 ACCEL, 2 CRUISE, 3 DECEL.
REQ-013 win_done  out  1  one-clock pulse, high on the cycle after each window closes.

Function
REQ-014 Window counter wcnt shall count 0..PERIOD-1 and wrap to 0.
REQ-015 Duty accumulator dacc shall add 1 on every clock where motor_pwm & motor_en is high.
REQ-016 On the edge where wcnt==PERIOD-1:
  - target = dacc + (motor_pwm & motor_en), i.e. the current sample is included;
  - dacc shall clear to 0;
  - speed shall update per REQ-017.
REQ-017 Slew rule (all arithmetic in SW+1 bits, no overflow or underflow):
  - target > speed: speed <= min(speed+ACCEL, target);
  - target < speed: speed <= max(speed-ACCEL, target);
  - target == speed: speed is unchanged.
REQ-018 mstate shall be registered on the same window edge as speed, using the post-update speed S' and the window target:
  - STOPPED if S'==0 and target==0;
  - ACCEL if S' < target;
  - DECEL if S' > target;
  - otherwise CRUISE.
REQ-019 win_done shall be high for exactly the one clock following each window-close edge.
REQ-020 Phase accumulator (ACC_W bits) shall add the registered speed every clock. Overflow means the sum is at least 2^ACC_W; the accumulator keeps sum mod 2^ACC_W.
REQ-021 On overflow, the following updates shall happen on the same edge:
  - motor_encdr toggles;
  - position increments if motor_dir==0 and decrements if motor_dir==1, with motor_dir sampled that cycle.
REQ-022 position shall wrap as 32-bit two's complement (0x7FFFFFFF+1 -> 0x80000000; 0 - 1 -> 0xFFFFFFFF).
REQ-023 When speed==0, the accumulator, motor_encdr and position shall hold.
REQ-024 motor_en low shall only zero the target; speed shall still decelerate at the ACCEL rate, with no instant stop.
REQ-025 A motor_dir change mid-window shall take effect on the next overflow; speed shall be unaffected.
REQ-026 Edge-to-edge period of motor_encdr = 2^ACC_W / speed clocks (average) while speed is constant.

Reset
REQ-027 While rst is high at a clock edge, the block shall clear:
  - wcnt, dacc and the accumulator;
  - speed, position, motor_encdr and win_done to 0;
  - mstate to STOPPED.
REQ-028 Reset asserted mid-window or mid-motion shall discard the partial window. The first window after release shall start at wcnt=0 on the first edge with rst low.
REQ-029 Outputs shall be defined from the first clock edge with rst high; no output is X after that edge.

Verification (PERIOD=1024, ACCEL=16, ACC_W=20)
REQ-030 Reset with all inputs 0 for 3000 clocks -> all outputs 0, mstate=STOPPED, win_done pulses every 1024 clocks.
REQ-031 motor_pwm=1, motor_en=1 constant:
  - speed = 16, 32, ... after windows 1, 2, ...;
  - mstate=ACCEL through window 63 (speed 1008);
  - speed=1024 and mstate=CRUISE after window 64;
  - motor_encdr then toggles every 1024 clocks and position increments by 1 per toggle.
REQ-032 From cruise at 1024, drop motor_en -> speed falls 16 per window with mstate=DECEL; after 64 windows speed=0, mstate=STOPPED, and motor_encdr/position freeze.
REQ-033 motor_pwm high 512 of every 1024 clocks, motor_en=1 -> speed=512 after 32 windows and then stays at 512 with mstate=CRUISE; motor_encdr toggles every 2048 clocks.
REQ-034 At cruise, set motor_dir=1 -> position decrements per toggle, passing 0 to 0xFFFFFFFF.
REQ-035 Preload by running forward, then pulse rst for 1 clock mid-window -> all state zero on the next cycle; the next win_done occurs exactly 1024 clocks after release.
